// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch front end. Runs the imem req/ack handshake,
//            buffers {pc,instr} in a prefetch FIFO, honours ID stall and
//            EX branch redirects, and feeds the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Hazard,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCIn,
    output logic [31:0] OrderIn,
    output logic        IF_IDFlash
);

    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [PW-1:0]   C_PTR1  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_REQ_DISC = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_addr;
    logic           r_req;

    logic [31:0]    r_pc_mem  [DEPTH];
    logic [31:0]    r_ins_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_nonempty;
    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_count_next;
    logic           w_space;
    logic [31:0]    w_addr_inc;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty & ~Hazard & ~BranchTaken;
    assign w_push     = (r_state == S_REQ) & imem_ack & ~BranchTaken;
    assign w_addr_inc = r_addr + 32'd4;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + C_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - C_ONE;
        end
    end

    assign w_space = (w_count_next < C_DEPTH);

    // FIFO occupancy and pointers; a branch empties the queue on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (BranchTaken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR1;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_addr;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    // Request sequencer: at most one request outstanding, held until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= 32'h0;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (BranchTaken) begin
                        r_fetch_pc <= BranchTarget;
                        r_addr     <= BranchTarget;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end else if ((r_count < C_DEPTH) || w_pop) begin
                        r_addr     <= r_fetch_pc;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack && BranchTaken) begin
                        r_fetch_pc <= BranchTarget;
                        r_addr     <= BranchTarget;
                    end else if (imem_ack) begin
                        r_fetch_pc <= w_addr_inc;
                        if (w_space) begin
                            r_addr  <= w_addr_inc;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (BranchTaken) begin
                        r_fetch_pc <= BranchTarget;
                        r_state    <= S_REQ_DISC;
                    end
                end
                S_REQ_DISC: begin
                    // The in-flight response belongs to the old path and is dropped
                    if (BranchTaken) begin
                        r_fetch_pc <= BranchTarget;
                    end
                    if (imem_ack) begin
                        r_addr  <= BranchTaken ? BranchTarget : r_fetch_pc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign IF_IDFlash = BranchTaken;
    assign PCIn       = w_nonempty ? r_pc_mem[r_rd_ptr]  : 32'h0;
    assign OrderIn    = w_nonempty ? r_ins_mem[r_rd_ptr] : 32'h0;

endmodule
`default_nettype wire
